pll_lock_sequencer: RTL and testbench
=====================================

Name: pll_lock_sequencer

Overview:
- Controller on the far side of the PLL wrapper: drives the PLL `rst` input and consumes its asynchronous `locked` output.
- Runs on the board reference clock (50 MHz), never on a PLL output.
- Holds the downstream CPU/coprocessor reset until lock has been stable for a programmable time.
- Re-resets the PLL on lock timeout or software request, and counts lock-loss events for debug.

Parameters:
- SYNC_STAGES, 2: flops in the `pll_locked` synchronizer chain (min 2).
- PLL_RST_CYCLES, 16: cycles `pll_rst` is held high per PLL reset pulse.
- TIMEOUT_CYCLES, 65536: max cycles in WAIT_LOCK before re-resetting the PLL.
- STABLE_CYCLES, 1024: consecutive synchronized-locked cycles required before releasing `sys_rst_n`.
- LOSS_CNT_W, 8: width of the saturating lock-loss counter.

Ports:
- clk, input, 1: board reference clock; all logic is on the rising edge.
- rst_n, input, 1: synchronous, active-low reset.
- pll_locked, input, 1: PLL `locked` output, asynchronous to `clk`.
- relock_req, input, 1: single-cycle request to re-reset the PLL; ignored unless in RUN.
- pll_rst, output, 1: active-high reset to the PLL.
- sys_rst_n, output, 1: active-low reset to downstream logic.
- lock_ok, output, 1: high only in RUN.
- timeout_err, output, 1: sticky; set on any WAIT_LOCK timeout.
- loss_count, output, LOSS_CNT_W: saturating count of RUN-to-lock-loss events.

Behaviour:
- Reset (rst_n=0 at a clock edge):
  - state=PLL_RESET; all counters=0; sync chain=0.
  - pll_rst=1, sys_rst_n=0, lock_ok=0, timeout_err=0, loss_count=0.
- Registering: all outputs are registered and change on the same edge as the state register.
- Synchronizer: `locked_s` is the last stage of a SYNC_STAGES flop chain on `pll_locked`. A `pll_locked` edge is visible in `locked_s` SYNC_STAGES cycles later.
- PLL_RESET:
  - pll_rst=1; cycle counter increments.
  - After PLL_RST_CYCLES cycles in this state -> WAIT_LOCK; pll_rst=0 on that edge; counter cleared.
- WAIT_LOCK:
  - Counter increments each cycle.
  - If locked_s=1 -> STABILIZE; counter cleared.
  - Else if counter reaches TIMEOUT_CYCLES-1 -> timeout_err=1, then PLL_RESET.
  - If both conditions hold on the same cycle, locked_s has priority.
- STABILIZE:
  - While locked_s=1, counter increments.
  - If locked_s=0 -> WAIT_LOCK; counter cleared. This is not a loss event.
  - When STABLE_CYCLES consecutive locked_s=1 cycles have been seen -> RUN. sys_rst_n=1 and lock_ok=1 on that edge.
- RUN:
  - If locked_s=0 -> WAIT_LOCK on the next edge. On that same edge: sys_rst_n=0, lock_ok=0, and loss_count increments, saturating at 2^LOSS_CNT_W-1.
  - Else if relock_req=1 -> PLL_RESET on the next edge, with sys_rst_n=0 and lock_ok=0. loss_count is unchanged.
  - If both occur on the same cycle, lock loss has priority; relock_req is dropped.
- Reset release latency: from the `pll_locked` rising edge to the `sys_rst_n` rising edge is SYNC_STAGES+1+STABLE_CYCLES cycles (±1 for async sampling).
- Reset assertion latency: from a `pll_locked` falling edge while in RUN to `sys_rst_n`=0 is at most SYNC_STAGES+1 cycles.
- Clearing: timeout_err and loss_count clear only on rst_n.
- rst_n mid-operation: returns to PLL_RESET from any state on the next edge, with all outputs at their reset values.
- Counter width: sized for max(PLL_RST_CYCLES, TIMEOUT_CYCLES, STABLE_CYCLES); counters never wrap.

Test Plan (bench params: SYNC_STAGES=2, PLL_RST_CYCLES=4, TIMEOUT_CYCLES=64, STABLE_CYCLES=8, LOSS_CNT_W=2):
- Power-up: release rst_n, pll_locked=0 -> pll_rst high exactly 4 cycles then low; sys_rst_n=0; lock_ok=0.
- Clean lock: raise pll_locked 10 cycles after pll_rst falls -> sys_rst_n and lock_ok rise 11 cycles (2+1+8) after the pll_locked edge; pll_rst stays 0.
- Glitch during STABILIZE: pll_locked low for 1 cycle 5 cycles after rising -> stability count restarts; sys_rst_n rises 11 cycles after the re-rise; loss_count=0.
- Timeout: pll_locked held 0 -> after 64 WAIT_LOCK cycles timeout_err=1 (sticky), a new 4-cycle pll_rst pulse follows, and the pattern repeats.
- Lock loss in RUN, 4 times: drop pll_locked -> sys_rst_n=0 within 3 cycles each time; loss_count reads 1, 2, 3, 3 (saturated).
- relock_req in RUN -> next edge pll_rst=1 (4 cycles) and sys_rst_n=0, loss_count unchanged. relock_req on the same cycle as lock loss -> loss path taken (WAIT_LOCK, loss_count+1, no pll_rst). rst_n=0 mid-STABILIZE -> every output back to its reset value next edge.

Source files
------------

// File: rtl/pll_lock_sequencer.sv
// pll_lock_sequencer: sequences PLL reset, waits for stable lock, then releases the downstream reset.
module pll_lock_sequencer #(
  parameter int SYNC_STAGES    = 2,
  parameter int PLL_RST_CYCLES = 16,
  parameter int TIMEOUT_CYCLES = 65536,
  parameter int STABLE_CYCLES  = 1024,
  parameter int LOSS_CNT_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  pll_locked,
  input  logic                  relock_req,
  output logic                  pll_rst,
  output logic                  sys_rst_n,
  output logic                  lock_ok,
  output logic                  timeout_err,
  output logic [LOSS_CNT_W-1:0] loss_count
);
  localparam int CNT_A   = PLL_RST_CYCLES > TIMEOUT_CYCLES ? PLL_RST_CYCLES : TIMEOUT_CYCLES;
  localparam int CNT_MAX = CNT_A > STABLE_CYCLES ? CNT_A : STABLE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  typedef enum logic [1:0] {PLL_RESET, WAIT_LOCK, STABILIZE, RUN} state_t;
  state_t                 state;
  logic [CW-1:0]          cnt;
  logic [SYNC_STAGES-1:0] sync;
  logic                   locked_s;
  assign locked_s = sync[SYNC_STAGES-1];
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= PLL_RESET;
      cnt         <= '0;
      sync        <= '0;
      pll_rst     <= 1'b1;
      sys_rst_n   <= 1'b0;
      lock_ok     <= 1'b0;
      timeout_err <= 1'b0;
      loss_count  <= '0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pll_locked};
      case (state)
        PLL_RESET:
          if (cnt == CW'(PLL_RST_CYCLES - 1)) begin
            state   <= WAIT_LOCK;
            pll_rst <= 1'b0;
            cnt     <= '0;
          end else cnt <= cnt + CW'(1);
        WAIT_LOCK:
          if (locked_s) begin
            state <= STABILIZE;
            cnt   <= '0;
          end else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            state       <= PLL_RESET;
            pll_rst     <= 1'b1;
            timeout_err <= 1'b1;
            cnt         <= '0;
          end else cnt <= cnt + CW'(1);
        STABILIZE:
          if (!locked_s) begin
            state <= WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == CW'(STABLE_CYCLES - 1)) begin
            state     <= RUN;
            sys_rst_n <= 1'b1;
            lock_ok   <= 1'b1;
            cnt       <= '0;
          end else cnt <= cnt + CW'(1);
        RUN:
          // lock loss outranks a software relock request
          if (!locked_s) begin
            state      <= WAIT_LOCK;
            sys_rst_n  <= 1'b0;
            lock_ok    <= 1'b0;
            loss_count <= loss_count == '1 ? loss_count : loss_count + LOSS_CNT_W'(1);
            cnt        <= '0;
          end else if (relock_req) begin
            state     <= PLL_RESET;
            pll_rst   <= 1'b1;
            sys_rst_n <= 1'b0;
            lock_ok   <= 1'b0;
            cnt       <= '0;
          end
        default: state <= PLL_RESET;
      endcase
    end
  end
endmodule

// File: tb/tb_pll_lock_sequencer.sv
// tb_pll_lock_sequencer: directed table plus hand sequences for the PLL lock sequencer.
module tb_pll_lock_sequencer;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       relock_req = 1'b0;
  logic       pll_rst, sys_rst_n, lock_ok, timeout_err;
  logic [1:0] loss_count;
  int         checks = 0;
  int         errors = 0;

  pll_lock_sequencer #(
    .SYNC_STAGES(2), .PLL_RST_CYCLES(4), .TIMEOUT_CYCLES(64), .STABLE_CYCLES(8), .LOSS_CNT_W(2)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_locked(pll_locked), .relock_req(relock_req),
    .pll_rst(pll_rst), .sys_rst_n(sys_rst_n), .lock_ok(lock_ok),
    .timeout_err(timeout_err), .loss_count(loss_count)
  );

  always #5 clk = ~clk;

  // expected outputs packed as {pll_rst, sys_rst_n, lock_ok, timeout_err, loss_count}
  typedef struct packed {
    logic       rst_n;
    logic       locked;
    logic       relock;
    logic [7:0] reps;
    logic [5:0] exp;
  } vec_t;
  vec_t tbl [14];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {pll_rst, sys_rst_n, lock_ok, timeout_err, loss_count};
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
    end
  endtask

  task automatic wait_run(input int max);
    int k = 0;
    while (!lock_ok && k < max) begin
      step();
      k++;
    end
    checks++;
    if (!lock_ok) begin
      errors++;
      $display("FAIL wait_run: lock_ok got 0 expected 1 within %0d cycles", max);
    end
  endtask

  initial begin
    tbl[0]  = {1'b0, 1'b0, 1'b0, 8'd2,  6'b100000};
    tbl[1]  = {1'b1, 1'b0, 1'b0, 8'd3,  6'b100000};
    tbl[2]  = {1'b1, 1'b0, 1'b0, 8'd1,  6'b000000};
    tbl[3]  = {1'b1, 1'b0, 1'b0, 8'd63, 6'b000000};
    tbl[4]  = {1'b1, 1'b0, 1'b0, 8'd1,  6'b100100};
    tbl[5]  = {1'b1, 1'b0, 1'b0, 8'd3,  6'b100100};
    tbl[6]  = {1'b1, 1'b0, 1'b0, 8'd1,  6'b000100};
    tbl[7]  = {1'b1, 1'b0, 1'b0, 8'd63, 6'b000100};
    tbl[8]  = {1'b1, 1'b0, 1'b0, 8'd1,  6'b100100};
    tbl[9]  = {1'b1, 1'b0, 1'b0, 8'd3,  6'b100100};
    tbl[10] = {1'b1, 1'b0, 1'b0, 8'd1,  6'b000100};
    tbl[11] = {1'b1, 1'b0, 1'b0, 8'd10, 6'b000100};
    tbl[12] = {1'b1, 1'b1, 1'b0, 8'd10, 6'b000100};
    tbl[13] = {1'b1, 1'b1, 1'b0, 8'd1,  6'b011100};
    for (int i = 0; i < 14; i++) begin
      rst_n      = tbl[i].rst_n;
      pll_locked = tbl[i].locked;
      relock_req = tbl[i].relock;
      for (int r = 0; r < int'(tbl[i].reps); r++) begin
        step();
        chk($sformatf("vec%0d_r%0d", i, r), tbl[i].exp);
      end
    end
    // software relock from RUN
    relock_req = 1'b1;
    step();
    relock_req = 1'b0;
    chk("relock_edge", 6'b100100);
    for (int r = 0; r < 3; r++) begin
      step();
      chk("relock_hold", 6'b100100);
    end
    step();
    chk("relock_fall", 6'b000100);
    for (int r = 0; r < 8; r++) begin
      step();
      chk("relock_stab", 6'b000100);
    end
    step();
    chk("relock_run", 6'b011100);
    // relock and lock loss seen on the same cycle
    pll_locked = 1'b0;
    step();
    chk("both_e0", 6'b011100);
    step();
    chk("both_e1", 6'b011100);
    relock_req = 1'b1;
    step();
    relock_req = 1'b0;
    chk("both_loss", 6'b000101);
    step();
    chk("both_wait", 6'b000101);
    // one-cycle glitch while stabilizing
    pll_locked = 1'b1;
    for (int r = 0; r < 5; r++) begin
      step();
      chk("glitch_pre", 6'b000101);
    end
    pll_locked = 1'b0;
    step();
    chk("glitch_low", 6'b000101);
    pll_locked = 1'b1;
    for (int r = 0; r < 10; r++) begin
      step();
      chk("glitch_restab", 6'b000101);
    end
    step();
    chk("glitch_run", 6'b011101);
    // rst_n asserted mid-STABILIZE
    pll_locked = 1'b0;
    for (int r = 0; r < 3; r++) step();
    chk("mid_loss", 6'b000110);
    pll_locked = 1'b1;
    for (int r = 0; r < 5; r++) step();
    chk("mid_stab", 6'b000110);
    rst_n = 1'b0;
    step();
    chk("mid_rst", 6'b100000);
    rst_n = 1'b1;
    wait_run(30);
    // repeated lock loss, counter saturates
    for (int i = 0; i < 4; i++) begin
      pll_locked = 1'b0;
      step();
      chk($sformatf("loss%0d_e0", i), {4'b0110, 2'(i)});
      step();
      chk($sformatf("loss%0d_e1", i), {4'b0110, 2'(i)});
      step();
      chk($sformatf("loss%0d_e2", i), {4'b0000, (i < 3) ? 2'(i + 1) : 2'd3});
      pll_locked = 1'b1;
      wait_run(30);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
